// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: coin credit, item vend, greedy change.
// Define VEND_STOCK_EN to enable per-item stock counters and OOS checks.
module vend_ctrl_param #(
   parameter int NUM_ITEMS = 9,
   parameter int CREDIT_W  = 8,
   parameter int STOCK_W   = 4,
   parameter int PRICE_RST = 25,
   parameter int STOCK_RST = 5,
   parameter int IDX_W     = $clog2(NUM_ITEMS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 coin_vld,
   input  logic [2:0]           coin_type,
   input  logic                 sel_vld,
   input  logic [IDX_W-1:0]     sel_idx,
   input  logic                 cancel,
   input  logic                 cfg_we,
   input  logic [IDX_W-1:0]     cfg_idx,
   input  logic [CREDIT_W-1:0]  cfg_price,
   input  logic [STOCK_W-1:0]   cfg_stock,
   output logic [CREDIT_W-1:0]  credit,
   output logic [CREDIT_W-1:0]  disp_val,
   output logic                 disp_price,
   output logic [NUM_ITEMS-1:0] led_g,
   output logic [NUM_ITEMS-1:0] led_r,
   output logic                 coin_rej,
   output logic                 sel_err,
   output logic                 vend_vld,
   output logic [IDX_W-1:0]     vend_idx,
   output logic                 chg_vld,
   output logic [2:0]           chg_coin,
   input  logic                 chg_rdy
);

   localparam int XW = CREDIT_W + 8;
   typedef logic [XW-1:0]       xw_t;
   typedef logic [CREDIT_W-1:0] cr_t;
   localparam logic [IDX_W:0] N_ITEMS = (IDX_W+1)'(NUM_ITEMS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CREDIT,
      S_VEND,
      S_CHANGE
   } state_t;

   function automatic logic [7:0] coin_val(input logic [2:0] t);
      case (t)
         3'd0:    coin_val = 8'd1;
         3'd1:    coin_val = 8'd2;
         3'd2:    coin_val = 8'd5;
         3'd3:    coin_val = 8'd10;
         3'd4:    coin_val = 8'd20;
         3'd5:    coin_val = 8'd100;
         default: coin_val = 8'd0;
      endcase
   endfunction

   // Largest returnable coin not exceeding the remaining credit.
   function automatic logic [2:0] change_pick(input cr_t c);
      xw_t cx;
      cx = xw_t'(c);
      if (cx >= xw_t'(100))     change_pick = 3'd5;
      else if (cx >= xw_t'(20)) change_pick = 3'd4;
      else if (cx >= xw_t'(5))  change_pick = 3'd2;
      else if (cx >= xw_t'(2))  change_pick = 3'd1;
      else                      change_pick = 3'd0;
   endfunction

   state_t           state_q, state_d;
   cr_t              credit_q, credit_d;
   cr_t              disp_val_q, disp_val_d;
   logic             disp_price_q, disp_price_d;
   logic             coin_rej_q, coin_rej_d;
   logic             sel_err_q, sel_err_d;
   logic             vend_vld_q, vend_vld_d;
   logic [IDX_W-1:0] vend_idx_q, vend_idx_d;
   logic             chg_vld_q, chg_vld_d;
   logic [2:0]       chg_coin_q, chg_coin_d;
   cr_t              price_q [NUM_ITEMS];
   cr_t              price_d [NUM_ITEMS];

   logic             sel_ok, cfg_ok, sel_oos;
   logic             coin_fit, coin_take;
   logic             vend_go, cfg_go;
   logic [IDX_W-1:0] sel_i, cfg_i;
   cr_t              sel_price;
   xw_t              coin_sum;

   assign sel_ok    = {1'b0, sel_idx} < N_ITEMS;
   assign cfg_ok    = {1'b0, cfg_idx} < N_ITEMS;
   assign sel_i     = sel_ok ? sel_idx : '0;
   assign cfg_i     = cfg_ok ? cfg_idx : '0;
   assign sel_price = price_q[sel_i];
   assign cfg_go    = cfg_we && cfg_ok && (state_q == S_IDLE);
   assign coin_sum  = xw_t'(credit_q) + xw_t'(coin_val(coin_type));
   assign coin_fit  = (coin_type <= 3'd5) &&
                      (coin_sum <= xw_t'({CREDIT_W{1'b1}}));

`ifdef VEND_STOCK_EN
   typedef logic [STOCK_W-1:0] st_t;
   st_t stock_q [NUM_ITEMS];
   st_t stock_d [NUM_ITEMS];

   assign sel_oos = (stock_q[sel_i] == '0);

   always_comb begin
      stock_d = stock_q;
      if (cfg_go) stock_d[cfg_i] = cfg_stock;
      if (vend_go) stock_d[sel_i] = stock_q[sel_i] - 1'b1;
   end
`else
   logic unused_stock;
   assign sel_oos      = 1'b0;
   assign unused_stock = ^{cfg_stock, STOCK_RST[0]};
`endif

   always_comb begin
      price_d = price_q;
      if (cfg_go) price_d[cfg_i] = cfg_price;
   end

   always_comb begin
      state_d      = state_q;
      credit_d     = credit_q;
      disp_val_d   = disp_val_q;
      disp_price_d = disp_price_q;
      sel_err_d    = 1'b0;
      vend_vld_d   = 1'b0;
      vend_idx_d   = vend_idx_q;
      chg_vld_d    = chg_vld_q;
      chg_coin_d   = chg_coin_q;
      coin_take    = 1'b0;
      vend_go      = 1'b0;
      unique case (state_q)
         S_IDLE, S_CREDIT: begin
            if (cancel) begin
               if (state_q == S_CREDIT) begin
                  state_d      = S_CHANGE;
                  chg_vld_d    = 1'b1;
                  chg_coin_d   = change_pick(credit_q);
                  disp_val_d   = credit_q;
                  disp_price_d = 1'b0;
               end
            end else if (sel_vld) begin
               if (!sel_ok) begin
                  sel_err_d = 1'b1;
               end else if (state_q == S_IDLE) begin
                  disp_val_d   = sel_price;
                  disp_price_d = 1'b1;
               end else if (sel_oos || credit_q < sel_price) begin
                  sel_err_d    = 1'b1;
                  disp_val_d   = sel_price;
                  disp_price_d = 1'b1;
               end else begin
                  vend_go      = 1'b1;
                  state_d      = S_VEND;
                  credit_d     = credit_q - sel_price;
                  vend_vld_d   = 1'b1;
                  vend_idx_d   = sel_idx;
                  disp_val_d   = credit_d;
                  disp_price_d = 1'b0;
               end
            end else if (coin_vld && coin_fit) begin
               coin_take    = 1'b1;
               credit_d     = coin_sum[CREDIT_W-1:0];
               state_d      = S_CREDIT;
               disp_val_d   = credit_d;
               disp_price_d = 1'b0;
            end
         end
         S_VEND: begin
            state_d    = (credit_q != '0) ? S_CHANGE : S_IDLE;
            chg_vld_d  = (credit_q != '0);
            chg_coin_d = change_pick(credit_q);
         end
         S_CHANGE: begin
            if (chg_vld_q && chg_rdy) begin
               credit_d   = credit_q - CREDIT_W'(coin_val(chg_coin_q));
               chg_vld_d  = (credit_d != '0);
               chg_coin_d = change_pick(credit_d);
               disp_val_d = credit_d;
               if (credit_d == '0) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      coin_rej_d = coin_vld && !coin_take;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         credit_q     <= '0;
         disp_val_q   <= '0;
         disp_price_q <= 1'b0;
         coin_rej_q   <= 1'b0;
         sel_err_q    <= 1'b0;
         vend_vld_q   <= 1'b0;
         vend_idx_q   <= '0;
         chg_vld_q    <= 1'b0;
         chg_coin_q   <= 3'd0;
         for (int i = 0; i < NUM_ITEMS; i++) begin
            price_q[i] <= CREDIT_W'(PRICE_RST);
`ifdef VEND_STOCK_EN
            stock_q[i] <= STOCK_W'(STOCK_RST);
`endif
         end
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         disp_val_q   <= disp_val_d;
         disp_price_q <= disp_price_d;
         coin_rej_q   <= coin_rej_d;
         sel_err_q    <= sel_err_d;
         vend_vld_q   <= vend_vld_d;
         vend_idx_q   <= vend_idx_d;
         chg_vld_q    <= chg_vld_d;
         chg_coin_q   <= chg_coin_d;
         price_q      <= price_d;
`ifdef VEND_STOCK_EN
         stock_q      <= stock_d;
`endif
      end
   end

   always_comb begin
      led_g = '0;
      led_r = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
`ifdef VEND_STOCK_EN
         led_g[i] = (credit_q >= price_q[i]) && (stock_q[i] != '0);
         led_r[i] = (stock_q[i] == '0);
`else
         led_g[i] = (credit_q >= price_q[i]);
`endif
      end
   end

   assign credit     = credit_q;
   assign disp_val   = disp_val_q;
   assign disp_price = disp_price_q;
   assign coin_rej   = coin_rej_q;
   assign sel_err    = sel_err_q;
   assign vend_vld   = vend_vld_q;
   assign vend_idx   = vend_idx_q;
   assign chg_vld    = chg_vld_q;
   assign chg_coin   = chg_coin_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Bench for vend_ctrl_param: directed scenarios plus random traffic
// checked against a money-level model of credit, prices and stock.
module tb_vend_ctrl_param;

   localparam int NI = 9;

`ifdef VEND_STOCK_EN
   localparam bit STK = 1'b1;
`else
   localparam bit STK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          coin_vld, sel_vld, cancel, cfg_we, chg_rdy;
   logic [2:0]    coin_type;
   logic [3:0]    sel_idx, cfg_idx;
   logic [7:0]    cfg_price;
   logic [3:0]    cfg_stock;
   logic [7:0]    credit, disp_val;
   logic          disp_price, coin_rej, sel_err, vend_vld, chg_vld;
   logic [NI-1:0] led_g, led_r;
   logic [3:0]    vend_idx;
   logic [2:0]    chg_coin;

   always #5 clk = ~clk;

   vend_ctrl_param dut (
      .clk(clk), .rst_n(rst_n),
      .coin_vld(coin_vld), .coin_type(coin_type),
      .sel_vld(sel_vld), .sel_idx(sel_idx),
      .cancel(cancel),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_price(cfg_price), .cfg_stock(cfg_stock),
      .credit(credit), .disp_val(disp_val), .disp_price(disp_price),
      .led_g(led_g), .led_r(led_r),
      .coin_rej(coin_rej), .sel_err(sel_err),
      .vend_vld(vend_vld), .vend_idx(vend_idx),
      .chg_vld(chg_vld), .chg_coin(chg_coin), .chg_rdy(chg_rdy)
   );

   int n_chk = 0;
   int n_fail = 0;
   int m_cred;
   int m_price [NI];
   int m_stock [NI];

   // Denominations in nickels, indexed by coin code; 0 = not a coin.
   function automatic int cval(int t);
      int tbl [6] = '{1, 2, 5, 10, 20, 100};
      if (t < 0 || t > 5) return 0;
      return tbl[t];
   endfunction

   function automatic int pick(int c);
      int order [5] = '{5, 4, 2, 1, 0};
      foreach (order[i]) if (cval(order[i]) <= c) return order[i];
      return 0;
   endfunction

   function automatic logic [NI-1:0] exp_g();
      logic [NI-1:0] g;
      for (int i = 0; i < NI; i++)
         g[i] = (m_cred >= m_price[i]) && (!STK || m_stock[i] != 0);
      return g;
   endfunction

   function automatic logic [NI-1:0] exp_r();
      logic [NI-1:0] r;
      for (int i = 0; i < NI; i++) r[i] = STK && (m_stock[i] == 0);
      return r;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cred = 0;
      for (int i = 0; i < NI; i++) begin
         m_price[i] = 25;
         m_stock[i] = 5;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      coin_vld = 1'b0;
      sel_vld  = 1'b0;
      cancel   = 1'b0;
      cfg_we   = 1'b0;
   endtask

   task automatic check_leds();
      chk("led_g", led_g, exp_g());
      chk("led_r", led_r, exp_r());
   endtask

   task automatic drain(int mode);
      int q [$];
      int rem, k, budget;
      bit rdy;
      rem = m_cred;
      while (rem > 0) begin
         q.push_back(pick(rem));
         rem -= cval(pick(rem));
      end
      rem = m_cred;
      k = 0;
      budget = 400;
      while (k < q.size() && budget > 0) begin
         chk("chg_vld", chg_vld, 1);
         chk("chg_coin", chg_coin, q[k]);
         chk("chg_credit", credit, rem);
         chk("chg_disp", disp_val, rem);
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = budget[0];
         endcase
         chg_rdy = rdy;
         cyc();
         chg_rdy = 1'b0;
         if (rdy) begin
            rem -= cval(q[k]);
            k++;
         end
         budget--;
      end
      m_cred = 0;
      chk("chg_vld_end", chg_vld, 0);
      chk("chg_credit_end", credit, 0);
   endtask

   task automatic do_coin(int t);
      int v;
      bit ok;
      v  = cval(t);
      ok = (t <= 5) && (m_cred + v <= 255);
      coin_vld  = 1'b1;
      coin_type = 3'(t);
      cyc();
      chk("coin_rej", coin_rej, !ok);
      if (ok) begin
         m_cred += v;
         chk("coin_disp", disp_val, m_cred);
         chk("coin_disp_price", disp_price, 0);
      end
      chk("coin_credit", credit, m_cred);
      check_leds();
   endtask

   task automatic do_sel(int idx, bit with_coin);
      bit bad, oos, vend;
      int p;
      bad = idx >= NI;
      p   = bad ? 0 : m_price[idx];
      oos = !bad && STK && m_stock[idx] == 0;
      vend = !bad && m_cred != 0 && !oos && m_cred >= p;
      sel_vld = 1'b1;
      sel_idx = 4'(idx);
      if (with_coin) begin
         coin_vld  = 1'b1;
         coin_type = 3'd0;
      end
      cyc();
      if (with_coin) chk("coin_rej_sel", coin_rej, 1);
      chk("sel_err", sel_err, !vend && (bad || m_cred != 0));
      chk("vend_vld", vend_vld, vend);
      if (!bad && !vend) begin
         chk("sel_disp", disp_val, p);
         chk("sel_disp_price", disp_price, 1);
      end
      if (vend) begin
         chk("vend_idx", vend_idx, idx);
         m_cred -= p;
         if (m_stock[idx] > 0) m_stock[idx]--;
         chk("vend_credit", credit, m_cred);
         chk("vend_disp", disp_val, m_cred);
         cyc();
         chk("vend_pulse_end", vend_vld, 0);
         if (m_cred > 0) drain(1);
         else chk("vend_no_chg", chg_vld, 0);
      end
      chk("sel_credit", credit, m_cred);
      check_leds();
   endtask

   task automatic do_cancel(int mode);
      cancel = 1'b1;
      cyc();
      if (m_cred > 0) drain(mode);
      else begin
         chk("cancel_idle_chg", chg_vld, 0);
         chk("cancel_idle_credit", credit, 0);
      end
   endtask

   task automatic do_cfg(int idx, int p, int s);
      cfg_we    = 1'b1;
      cfg_idx   = 4'(idx);
      cfg_price = 8'(p);
      cfg_stock = 4'(s);
      cyc();
      if (m_cred == 0 && idx < NI) begin
         m_price[idx] = p;
         m_stock[idx] = s;
      end
      check_leds();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      coin_vld = 0; coin_type = 0; sel_vld = 0; sel_idx = 0;
      cancel = 0; cfg_we = 0; cfg_idx = 0; cfg_price = 0;
      cfg_stock = 0; chg_rdy = 0;
      rst_n = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      #11;
      chk("rst_credit", credit, 0);
      chk("rst_disp", disp_val, 0);
      chk("rst_disp_price", disp_price, 0);
      chk("rst_chg_vld", chg_vld, 0);
      chk("rst_vend_vld", vend_vld, 0);
      chk("rst_coin_rej", coin_rej, 0);
      chk("rst_sel_err", sel_err, 0);
      check_leds();
      @(negedge clk);
      rst_n = 1'b1;

      // 30 credit, item0 at 25, one quarter back
      do_coin(2); do_coin(2); do_coin(4);
      do_sel(0, 1'b0);

      // price peek and insufficient credit
      do_cfg(3, 40, 5);
      do_sel(3, 1'b0);
      do_coin(4);
      do_sel(3, 1'b0);
      do_cfg(0, 1, 0);
      do_cancel(0);
      do_sel(0, 1'b0);
      do_sel(12, 1'b0);
      do_cfg(10, 7, 7);

      // credit ceiling and invalid coins
      do_coin(5); do_coin(5); do_coin(4); do_coin(4); do_coin(3);
      do_coin(5); do_coin(6); do_coin(7);
      do_coin(1); do_coin(2);
      do_coin(0); do_coin(0); do_coin(0); do_coin(0);
      do_cancel(0);

      // 138 returned as 100,20,5,5,5,2,1 with a stalling receiver
      do_coin(5); do_coin(4); do_coin(3); do_coin(2); do_coin(1); do_coin(0);
      do_cancel(2);

      // single-stock item sold out after one vend
      do_cfg(2, 25, 1);
      do_coin(4); do_coin(2);
      do_sel(2, 1'b0);
      do_coin(4); do_coin(2);
      do_sel(2, 1'b0);
      do_cancel(0);

      // reset while change is pending
      do_coin(4); do_coin(3);
      cancel = 1'b1;
      cyc();
      chk("pre_rst_chg_vld", chg_vld, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_credit", credit, 0);
      chk("mid_rst_chg_vld", chg_vld, 0);
      chk("mid_rst_disp", disp_val, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      do_sel(0, 1'b1);
      do_coin(2);
      do_sel(1, 1'b1);
      do_cancel(0);

      for (int it = 0; it < 300; it++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op < 5) do_coin(int'($urandom_range(0, 7)));
         else if (op < 8)
            do_sel(int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
         else if (op == 8) do_cancel(1);
         else do_cfg(int'($urandom_range(0, 10)),
                     int'($urandom_range(1, 60)),
                     int'($urandom_range(0, 3)));
      end
      do_cancel(1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
